// File: rtl/chunked_adder_seq_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM states and default widths.
package chunked_adder_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunked_adder_seq_ripple.sv
// Combinational N-bit ripple-carry adder built from 1-bit full-adder cells.
module ripple_adder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[N];

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle add/subtract: one CHUNK-bit ripple slice reused over WIDTH/CHUNK cycles
// with a registered inter-chunk carry and valid/ready handshakes on both sides.
module chunked_adder_seq
  import chunked_adder_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("chunked_adder_seq: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [IDX_W-1:0] chunk_idx;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_next;

  // Operands shift right each BUSY cycle so the slice always sees the low CHUNK bits.
  ripple_adder_n #(.N(CHUNK)) u_slice (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .c_in (carry),
    .sum  (slice_sum),
    .c_out(slice_cout)
  );

  // Slice results enter at the top of sum; after NCHUNK shifts every chunk sits in place.
  if (CHUNK == WIDTH) begin : g_single_chunk
    assign sum_next = slice_sum;
  end else begin : g_multi_chunk
    assign sum_next = {slice_sum, sum[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      chunk_idx <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh      <= a;
            b_sh      <= b ^ {WIDTH{sub}};
            carry     <= c_in ^ sub;
            chunk_idx <= '0;
            in_ready  <= 1'b0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          sum   <= sum_next;
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          carry <= slice_cout;
          if (chunk_idx == IDX_W'(NCHUNK - 1)) begin
            // The final slice holds the operand MSBs, so overflow is decided here.
            chunk_idx <= '0;
            c_out     <= slice_cout;
            overflow  <= (a_sh[CHUNK-1] == b_sh[CHUNK-1]) &&
                         (slice_sum[CHUNK-1] != a_sh[CHUNK-1]);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            chunk_idx <= chunk_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
